// File: rtl/obi_arb_pkg.sv
// Shared definitions for the OBI data-side arbiter: requester port indices and payload structs.
// The AMO lock feature of the arbiter is enabled by defining OBI_ARB_AMO_LOCK_EN.
package obi_arb_pkg;

    localparam int LOAD_PORT  = 0;
    localparam int STORE_PORT = 1;
    localparam int AMO_PORT   = 2;
    localparam int PTW_PORT   = 3;

    localparam int OBI_ADDR_W = 56;
    localparam int OBI_DATA_W = 64;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0]   addr;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_DATA_W-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_rsp_t;

endpackage

// File: rtl/obi_arb_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module obi_arb_rr #(
    parameter  int NrReq = 4,
    localparam int IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic [NrReq-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    int cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int i = 0; i < NrReq; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NrReq) cand = cand - NrReq;
            if (!valid_o && req_i[IdxW'(cand)]) begin
                idx_o   = IdxW'(cand);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_data_arbiter.sv
// N:1 OBI data arbiter: round-robin with grant lock, outstanding limit and ID-routed responses.
// Define OBI_ARB_AMO_LOCK_EN to reserve the manager port for the AMO requester until its response.
module obi_data_arbiter
    import obi_arb_pkg::*;
#(
    parameter  int NrReq          = 4,
    parameter  int AddrWidth      = 56,
    parameter  int DataWidth      = 64,
    parameter  int MaxOutstanding = 4,
    parameter  int RidWidth       = (NrReq > 1) ? $clog2(NrReq) : 1,
    localparam int IdxW           = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NrReq-1:0]                      s_req_i,
    output logic [NrReq-1:0]                      s_gnt_o,
    input  logic [NrReq-1:0][AddrWidth-1:0]       s_addr_i,
    input  logic [NrReq-1:0]                      s_we_i,
    input  logic [NrReq-1:0][DataWidth/8-1:0]     s_be_i,
    input  logic [NrReq-1:0][DataWidth-1:0]       s_wdata_i,
    output logic [NrReq-1:0]                      s_rvalid_o,
    input  logic [NrReq-1:0]                      s_rready_i,
    output logic [DataWidth-1:0]                  s_rdata_o,
    output logic                                  s_err_o,
    output logic                                  m_req_o,
    input  logic                                  m_gnt_i,
    output logic [AddrWidth-1:0]                  m_addr_o,
    output logic                                  m_we_o,
    output logic [DataWidth/8-1:0]                m_be_o,
    output logic [DataWidth-1:0]                  m_wdata_o,
    output logic [IdxW-1:0]                       m_aid_o,
    input  logic                                  m_rvalid_i,
    output logic                                  m_rready_o,
    input  logic [RidWidth-1:0]                   m_rid_i,
    input  logic [DataWidth-1:0]                  m_rdata_i,
    input  logic                                  m_err_i,
    output logic                                  rid_err_o
);

    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic             lock_valid_q, lock_valid_d;
    logic [IdxW-1:0]  lock_idx_q, lock_idx_d;
    logic [3:0]       outst_q, outst_d;
    logic             rid_err_q, rid_err_d;

    logic [NrReq-1:0] req_mask;
    logic [IdxW-1:0]  rr_idx;
    logic             rr_valid;
    logic [IdxW-1:0]  sel;
    logic             sel_valid;
    logic             blocked;
    logic             req_hs;
    logic             rsp_hs;
    logic             rid_oob;

`ifdef OBI_ARB_AMO_LOCK_EN
    localparam logic [NrReq-1:0] AmoMask = NrReq'(1) << AMO_PORT;
    logic amo_lock_q, amo_lock_d;

    always_comb begin
        req_mask = amo_lock_q ? (s_req_i & AmoMask) : s_req_i;
    end
`else
    always_comb begin
        req_mask = s_req_i;
    end
`endif

    obi_arb_rr #(.NrReq(NrReq)) u_rr (
        .req_i   (req_mask),
        .ptr_i   (ptr_q),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    // A port presented without grant keeps the manager port until its handshake.
    always_comb begin
        if (lock_valid_q && s_req_i[lock_idx_q]) begin
            sel       = lock_idx_q;
            sel_valid = 1'b1;
        end else begin
            sel       = rr_idx;
            sel_valid = rr_valid;
        end
        blocked   = (outst_q == 4'(MaxOutstanding));
        m_req_o   = sel_valid & ~blocked & ~rst_i;
        m_aid_o   = sel;
        m_addr_o  = s_addr_i[sel];
        m_we_o    = s_we_i[sel];
        m_be_o    = s_be_i[sel];
        m_wdata_o = s_wdata_i[sel];
        req_hs    = m_req_o & m_gnt_i;
        for (int i = 0; i < NrReq; i++) begin
            s_gnt_o[i] = req_hs & (sel == IdxW'(i));
        end
    end

    // Responses carrying an unknown ID are accepted and dropped so the manager never stalls.
    always_comb begin
        rid_oob    = (int'(m_rid_i) >= NrReq);
        s_rvalid_o = '0;
        m_rready_o = 1'b0;
        if (!rst_i) begin
            if (rid_oob) begin
                m_rready_o = 1'b1;
            end else begin
                for (int i = 0; i < NrReq; i++) begin
                    if (int'(m_rid_i) == i) begin
                        s_rvalid_o[i] = m_rvalid_i;
                        m_rready_o    = s_rready_i[i];
                    end
                end
            end
        end
        rsp_hs    = m_rvalid_i & m_rready_o;
        s_rdata_o = m_rdata_i;
        s_err_o   = m_err_i;
    end

    always_comb begin
        ptr_d        = ptr_q;
        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        outst_d      = outst_q;
        rid_err_d    = rid_err_q | (m_rvalid_i & rid_oob);

        if (req_hs) begin
            ptr_d = (sel == IdxW'(NrReq - 1)) ? '0 : sel + IdxW'(1);
        end

        if (m_req_o && !m_gnt_i) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = sel;
        end else if (req_hs) begin
            lock_valid_d = 1'b0;
        end

        if (req_hs && !(rsp_hs && outst_q != 4'd0)) begin
            outst_d = outst_q + 4'd1;
        end else if (!req_hs && rsp_hs && outst_q != 4'd0) begin
            outst_d = outst_q - 4'd1;
        end
    end

`ifdef OBI_ARB_AMO_LOCK_EN
    always_comb begin
        amo_lock_d = amo_lock_q;
        if (req_hs && sel == IdxW'(AMO_PORT)) begin
            amo_lock_d = 1'b1;
        end else if (rsp_hs && int'(m_rid_i) == AMO_PORT) begin
            amo_lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) amo_lock_q <= 1'b0;
        else       amo_lock_q <= amo_lock_d;
    end
`endif

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q        <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            outst_q      <= 4'd0;
            rid_err_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            outst_q      <= outst_d;
            rid_err_q    <= rid_err_d;
        end
    end

    assign rid_err_o = rid_err_q;

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Self-checking bench for obi_data_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_obi_data_arbiter;
    import obi_arb_pkg::*;

    localparam int N       = 4;
    localparam int MAX_OUT = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          s_req;
    logic [N-1:0]          s_gnt;
    logic [N-1:0][55:0]    s_addr;
    logic [N-1:0]          s_we;
    logic [N-1:0][7:0]     s_be;
    logic [N-1:0][63:0]    s_wdata;
    logic [N-1:0]          s_rvalid;
    logic [N-1:0]          s_rready;
    logic [63:0]           s_rdata;
    logic                  s_err;
    logic                  m_req;
    logic                  m_gnt;
    logic [55:0]           m_addr;
    logic                  m_we;
    logic [7:0]            m_be;
    logic [63:0]           m_wdata;
    logic [1:0]            m_aid;
    logic                  m_rvalid;
    logic                  m_rready;
    logic [2:0]            m_rid;
    logic [63:0]           m_rdata;
    logic                  m_err;
    logic                  rid_err;

    obi_data_arbiter #(
        .NrReq(N), .AddrWidth(56), .DataWidth(64), .MaxOutstanding(MAX_OUT), .RidWidth(3)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_req_i(s_req), .s_gnt_o(s_gnt), .s_addr_i(s_addr), .s_we_i(s_we),
        .s_be_i(s_be), .s_wdata_i(s_wdata), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
        .s_rdata_o(s_rdata), .s_err_o(s_err),
        .m_req_o(m_req), .m_gnt_i(m_gnt), .m_addr_o(m_addr), .m_we_o(m_we),
        .m_be_o(m_be), .m_wdata_o(m_wdata), .m_aid_o(m_aid),
        .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rid_i(m_rid),
        .m_rdata_i(m_rdata), .m_err_i(m_err), .rid_err_o(rid_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state, expressed in terms of the arbitration rules.
    int mdl_ptr, mdl_outst, mdl_lock_idx;
    bit mdl_locked, mdl_rid_err, mdl_amo;
    logic [N-1:0] exp_gnt_last;

    logic         obs_req, obs_rready, obs_rid_err;
    logic [1:0]   obs_aid;
    logic [N-1:0] obs_gnt, obs_rvalid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int i);
        obi_req_t p;
        p.addr  = 56'({$urandom(), $urandom()});
        p.we    = 1'($urandom_range(0, 1));
        p.be    = 8'($urandom());
        p.wdata = {$urandom(), $urandom()};
        s_addr[i]  = p.addr;
        s_we[i]    = p.we;
        s_be[i]    = p.be;
        s_wdata[i] = p.wdata;
    endtask

    task automatic model_reset();
        mdl_ptr = 0; mdl_outst = 0; mdl_lock_idx = 0;
        mdl_locked = 0; mdl_rid_err = 0; mdl_amo = 0;
        exp_gnt_last = '0;
    endtask

    // One clock cycle: check outputs against the model, then advance the model at the edge.
    task automatic step();
        logic [N-1:0] reqv, e_gnt, e_rvalid;
        bit win_valid, e_req, e_rready, hs, rsp;
        int win, rid;
        #1;
        reqv = s_req;
        if (mdl_amo) reqv = reqv & 4'b0100;
        win_valid = 0;
        win = 0;
        if (mdl_locked && s_req[mdl_lock_idx]) begin
            win = mdl_lock_idx;
            win_valid = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!win_valid && reqv[(mdl_ptr + k) % N]) begin
                    win = (mdl_ptr + k) % N;
                    win_valid = 1;
                end
            end
        end
        e_req = win_valid && (mdl_outst < MAX_OUT);
        e_gnt = (e_req && m_gnt) ? (4'b0001 << win) : 4'b0000;
        rid = int'(m_rid);
        if (rid >= N) begin
            e_rvalid = '0;
            e_rready = 1;
        end else begin
            e_rvalid = m_rvalid ? (4'b0001 << rid) : 4'b0000;
            e_rready = s_rready[rid];
        end

        obs_req = m_req; obs_gnt = s_gnt; obs_aid = m_aid;
        obs_rvalid = s_rvalid; obs_rready = m_rready; obs_rid_err = rid_err;

        check("m_req", 64'(m_req), 64'(e_req));
        check("s_gnt", 64'(s_gnt), 64'(e_gnt));
        check("s_rvalid", 64'(s_rvalid), 64'(e_rvalid));
        check("rid_err", 64'(rid_err), 64'(mdl_rid_err));
        check("s_rdata", s_rdata, m_rdata);
        if (e_req) begin
            check("m_aid", 64'(m_aid), 64'(win));
            check("m_addr", 64'(m_addr), 64'(s_addr[win]));
            check("m_wdata", m_wdata, s_wdata[win]);
            check("m_be_we", 64'({m_be, m_we}), 64'({s_be[win], s_we[win]}));
        end
        if (m_rvalid) check("m_rready", 64'(m_rready), 64'(e_rready));

        @(posedge clk);
        hs  = e_req && m_gnt;
        rsp = m_rvalid && e_rready;
        if (m_rvalid && rid >= N) mdl_rid_err = 1;
        if (hs) mdl_ptr = (win + 1) % N;
        if (e_req && !m_gnt) begin
            mdl_locked = 1;
            mdl_lock_idx = win;
        end else if (hs) begin
            mdl_locked = 0;
        end
        mdl_outst = mdl_outst + (hs ? 1 : 0) - (rsp ? 1 : 0);
`ifdef OBI_ARB_AMO_LOCK_EN
        if (hs && win == AMO_PORT) mdl_amo = 1;
        else if (rsp && rid == AMO_PORT) mdl_amo = 0;
`endif
        exp_gnt_last = e_gnt;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        s_req = '0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rid = '0;
        s_rready = '1; m_rdata = '0; m_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_req = '1; m_rvalid = 1'b1; m_rid = 3'd1;
        #1;
        check("rst_m_req", 64'(m_req), 64'd0);
        check("rst_s_gnt", 64'(s_gnt), 64'd0);
        check("rst_s_rvalid", 64'(s_rvalid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_rid_err", 64'(rid_err), 64'd0);
        rst = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    task automatic drain();
        int budget = 20;
        s_req = '0; m_gnt = 1'b0; s_rready = '1; m_rid = 3'd0;
        while (mdl_outst > 0 && budget > 0) begin
            m_rvalid = 1'b1;
            step();
            budget--;
        end
        m_rvalid = 1'b0;
        check("drain_done", 64'(mdl_outst), 64'd0);
    endtask

    initial begin
        int exp_aid[4] = '{0, 3, 0, 3};
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < N; i++) new_payload(i);
        @(negedge clk);
        do_reset();

        // Ports 0 and 3 alternate under continuous grant with responses keeping slack.
        s_req = 4'b1001; m_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            m_rvalid = (c > 0);
            m_rid = 3'(exp_aid[(c + 3) % 4]);
            step();
            check("rr_aid", 64'(obs_aid), 64'(exp_aid[c]));
        end
        drain();

        // Port 1 stalled without grant stays selected after port 0 appears.
        s_req = 4'b0010; m_gnt = 1'b0;
        step();
        check("lock_aid_c1", 64'(obs_aid), 64'd1);
        s_req = 4'b0011;
        step();
        check("lock_aid_c2", 64'(obs_aid), 64'd1);
        step();
        check("lock_aid_c3", 64'(obs_aid), 64'd1);
        m_gnt = 1'b1;
        step();
        check("lock_gnt_c4", 64'(obs_gnt), 64'b0010);
        s_req = 4'b0001;
        step();
        check("lock_then_p0", 64'(obs_gnt), 64'b0001);
        drain();

        // Outstanding limit blocks the fifth request, including the cycle the response arrives.
        s_req = 4'b0010; m_gnt = 1'b1;
        repeat (4) step();
        step();
        check("limit_block", 64'(obs_req), 64'd0);
        m_rvalid = 1'b1; m_rid = 3'd2;
        step();
        check("limit_same_cycle", 64'(obs_req), 64'd0);
        m_rvalid = 1'b0;
        step();
        check("limit_unblock", 64'(obs_gnt), 64'b0010);

        // Response to port 3 waits on its ready.
        s_req = '0; m_rvalid = 1'b1; m_rid = 3'd3; s_rready = 4'b0111;
        repeat (2) begin
            step();
            check("rsp_wait_rready", 64'(obs_rready), 64'd0);
            check("rsp_wait_rvalid", 64'(obs_rvalid), 64'b1000);
        end
        s_req = 4'b0001;
        step();
        check("limit_still_full", 64'(obs_req), 64'd0);
        s_req = '0; s_rready = '1;
        step();
        check("rsp_ready", 64'(obs_rready), 64'd1);
        drain();

        // Unknown response ID is dropped and flagged until reset.
        s_req = 4'b1000; m_gnt = 1'b1;
        step();
        s_req = '0; m_rvalid = 1'b1; m_rid = 3'd5;
        step();
        check("oob_rready", 64'(obs_rready), 64'd1);
        check("oob_rvalid", 64'(obs_rvalid), 64'd0);
        m_rvalid = 1'b0;
        step();
        check("oob_sticky1", 64'(obs_rid_err), 64'd1);
        step();
        check("oob_sticky2", 64'(obs_rid_err), 64'd1);
        check("oob_outst", 64'(mdl_outst), 64'd0);
        do_reset();
        step();
        check("oob_cleared", 64'(obs_rid_err), 64'd0);

        // AMO grant followed by a load request.
        s_req = 4'b0100; m_gnt = 1'b1;
        step();
        check("amo_gnt", 64'(obs_gnt), 64'b0100);
        s_req = 4'b0001;
        step();
`ifdef OBI_ARB_AMO_LOCK_EN
        check("amo_lock_p0", 64'(obs_gnt), 64'b0000);
        m_rvalid = 1'b1; m_rid = 3'd2;
        step();
        check("amo_rsp_p0", 64'(obs_gnt), 64'b0000);
        m_rvalid = 1'b0;
        step();
        check("amo_after_p0", 64'(obs_gnt), 64'b0001);
`else
        check("amo_nolock_p0", 64'(obs_gnt), 64'b0001);
`endif
        drain();

        // Randomized traffic; pending requests and their payload hold until granted.
        s_req = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_req[i] || exp_gnt_last[i]) begin
                    s_req[i] = ($urandom_range(0, 2) == 0);
                    if (s_req[i]) new_payload(i);
                end
            end
            m_gnt    = ($urandom_range(0, 3) != 0);
            m_rvalid = (mdl_outst > 0) && ($urandom_range(0, 1) == 1);
            m_rid    = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            s_rready = 4'($urandom());
            m_rdata  = {$urandom(), $urandom()};
            m_err    = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obi_data_arbiter.md
OBI_DATA_ARBITER -- requirements
Module: obi_data_arbiter

Interface
REQ-001 Parameter NrReq, default 4, number of requester ports (0=load, 1=store, 2=AMO, 3=MMU PTW).
REQ-002 Parameter AddrWidth, default 56, request address width (PLEN).
REQ-003 Parameter DataWidth, default 64, data width (XLEN).
REQ-004 Parameter MaxOutstanding, default 4, accepted-but-unanswered transaction limit; legal range 1..15.
REQ-005 Port clk_i, in, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_i, in, 1: reset, synchronous, active-high.
REQ-007 Ports s_req_i, in, NrReq: per-requester request valid.
REQ-008 Ports s_gnt_o, out, NrReq: per-requester grant.
REQ-009 Ports s_addr_i, in, NrReq x AddrWidth; s_we_i, in, NrReq; s_be_i, in, NrReq x DataWidth/8; s_wdata_i, in, NrReq x DataWidth: request payload.
REQ-010 Ports s_rvalid_o, out, NrReq; s_rready_i, in, NrReq; s_rdata_o, out, DataWidth; s_err_o, out, 1: response channel.
REQ-011 Ports m_req_o, out, 1; m_gnt_i, in, 1; m_addr_o, m_we_o, m_be_o, m_wdata_o, out, payload widths; m_aid_o, out, $clog2(NrReq): manager request.
REQ-012 Ports m_rvalid_i, in, 1; m_rready_o, out, 1; m_rid_i, in, $clog2(NrReq); m_rdata_i, in, DataWidth; m_err_i, in, 1: manager response.
REQ-013 Port rid_err_o, out, 1: sticky flag, set on response with m_rid_i >= NrReq.

Function
REQ-014 Arbitration SHALL be round-robin: winner = first asserted s_req_i at or after pointer ptr, wrapping modulo NrReq.
REQ-015 ptr SHALL advance to (winner+1) mod NrReq only on handshake m_req_o & m_gnt_i; otherwise hold.
REQ-016 While m_req_o=1 and m_gnt_i=0, the selected port SHALL stay locked (registered) until handshake, even if a higher-priority request appears; payload forwarded unchanged.
REQ-017 m_req_o, m_aid_o and payload SHALL be combinational from the selected port; m_aid_o = selected index.
REQ-018 s_gnt_o[i] SHALL equal m_gnt_i & m_req_o & (selected==i); at most one bit high per cycle.
REQ-019 Counter outst (4 bits): +1 on request handshake, -1 on m_rvalid_i & m_rready_o, unchanged when both same cycle.
REQ-020 outst == MaxOutstanding SHALL force m_req_o=0 and all s_gnt_o=0; a simultaneous response does not unblock the same cycle.
REQ-021 Response routing: s_rvalid_o[m_rid_i] = m_rvalid_i; m_rready_o = s_rready_i[m_rid_i]; s_rdata_o/s_err_o = m_rdata_i/m_err_i broadcast.
REQ-022 m_rid_i >= NrReq with m_rvalid_i: m_rready_o=1, no s_rvalid_o, response dropped, outst decremented, rid_err_o set until reset.
REQ-023 Zero-latency path: request accepted in cycle N is visible on m_* in cycle N; no added pipeline stage.

Reset
REQ-024 On rst_i=1 at clock edge: ptr=0, lock cleared, outst=0, rid_err_o=0, AMO lock cleared.
REQ-025 During and after reset cycle: m_req_o=0, all s_gnt_o=0, all s_rvalid_o=0 until rst_i deasserts; in-flight responses after reset are treated as unknown-rid per REQ-022 only if rid out of range, otherwise routed.

Configuration
REQ-026 Macro OBI_ARB_AMO_LOCK_EN defined: after AMO port (index 2) handshake, only port 2 may win until its response handshake; outst increment/decrement unchanged.
REQ-027 Macro undefined: no AMO lock; port 2 arbitrates as any other port; lock register absent.

Structure
REQ-028 Shared package obi_arb_pkg SHALL hold requester index constants (LOAD_PORT=0, STORE_PORT=1, AMO_PORT=2, PTW_PORT=3) and the request/response payload struct typedefs.
REQ-029 One sub-module obi_arb_rr: round-robin pick from request vector and ptr, combinational, returns winner index and valid.

Verification
REQ-030 Ports 0 and 3 request every cycle, m_gnt_i=1, slack outstanding -> grants alternate 0,3,0,3; m_aid_o matches.
REQ-031 Port 1 requests, m_gnt_i=0 for 3 cycles, port 0 raises request cycle 2 -> m_aid_o stays 1 until grant cycle 4, then port 0.
REQ-032 MaxOutstanding=4, 4 grants, no responses -> 5th request stalls, m_req_o=0; one response with rid=2 -> outst=3, next cycle grant issued.
REQ-033 Response m_rid_i=3, s_rready_i[3]=0 for 2 cycles -> m_rready_o=0 held, s_rvalid_o=4'b1000, outst unchanged until ready.
REQ-034 Response with m_rid_i=5 (NrReq=4, width 3) -> m_rready_o=1, no s_rvalid_o, rid_err_o=1 sticky; rst_i clears it.
REQ-035 With OBI_ARB_AMO_LOCK_EN, AMO granted, port 0 requesting -> port 0 ungranted until AMO response handshake, then granted next cycle; without macro, port 0 granted immediately.
